// File: rtl/mem_router.sv
// Routes the arbiter's single memory port to RAM, UART or timer by address decode,
// issuing a one-cycle slave request and returning ready/rdata, or an error response.
module mem_router #(
    parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
    parameter logic [31:0] RAM_MASK   = 32'hFFF0_0000,
    parameter logic [31:0] UART_BASE  = 32'h1000_0000,
    parameter logic [31:0] UART_MASK  = 32'hFFFF_F000,
    parameter logic [31:0] TIMER_BASE = 32'h2000_0000,
    parameter logic [31:0] TIMER_MASK = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_valid,
    input  logic        memory_instr,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_wstrb,
    output logic [31:0] memory_rdata,
    output logic        memory_ready,
    output logic        memory_error,
    output logic        slv_instr,
    output logic [31:0] slv_addr,
    output logic [31:0] slv_wdata,
    output logic [3:0]  slv_wstrb,
    output logic        ram_valid,
    output logic        uart_valid,
    output logic        timer_valid,
    input  logic        ram_ready,
    input  logic        uart_ready,
    input  logic        timer_ready,
    input  logic [31:0] ram_rdata,
    input  logic [31:0] uart_rdata,
    input  logic [31:0] timer_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_RAM, SEL_UART, SEL_TIMER} sel_t;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    state_t        state_q, state_d;
    sel_t          sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          instr_q, instr_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;

    logic          hitRam, hitUart, hitTimer;
    logic          selReady, timeoutHit;
    logic [31:0]   selRdata;
    logic [CW-1:0] cntInc;

    assign slv_instr = instr_q;
    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;
    assign slv_wstrb = wstrb_q;

    assign hitRam   = (memory_addr & RAM_MASK)   == RAM_BASE;
    assign hitUart  = (memory_addr & UART_MASK)  == UART_BASE;
    assign hitTimer = (memory_addr & TIMER_MASK) == TIMER_BASE;

    // Only the latched selection may complete a transaction; other readies are ignored.
    always_comb begin
        selReady = 1'b0;
        selRdata = 32'h0;
        case (sel_q)
            SEL_RAM:   begin selReady = ram_ready;   selRdata = ram_rdata;   end
            SEL_UART:  begin selReady = uart_ready;  selRdata = uart_rdata;  end
            SEL_TIMER: begin selReady = timer_ready; selRdata = timer_rdata; end
            default:   begin selReady = 1'b0;        selRdata = 32'h0;       end
        endcase
    end

    // Counter saturates at TIMEOUT; with TIMEOUT=0 it never matches and WAIT holds forever.
    assign cntInc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    assign timeoutHit = (TIMEOUT != 0) && (cnt_q == CNT_MAX);

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        instr_d      = instr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        memory_ready = 1'b0;
        memory_error = 1'b0;
        memory_rdata = 32'h0;
        ram_valid    = 1'b0;
        uart_valid   = 1'b0;
        timer_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (memory_valid) begin
                    instr_d = memory_instr;
                    addr_d  = memory_addr;
                    wdata_d = memory_wdata;
                    wstrb_d = memory_wstrb;
                    cnt_d   = '0;
                    state_d = REQ;
                    if (hitRam) begin
                        sel_d = SEL_RAM;
                    end else if (hitUart && !memory_instr) begin
                        sel_d = SEL_UART;
                    end else if (!hitUart && hitTimer && !memory_instr) begin
                        sel_d = SEL_TIMER;
                    end else begin
                        sel_d   = SEL_NONE;
                        state_d = ERR;
                    end
                end
            end
            REQ: begin
                ram_valid   = (sel_q == SEL_RAM);
                uart_valid  = (sel_q == SEL_UART);
                timer_valid = (sel_q == SEL_TIMER);
                cnt_d       = cntInc;
                if (selReady) begin
                    memory_ready = 1'b1;
                    memory_rdata = selRdata;
                    sel_d        = SEL_NONE;
                    state_d      = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cntInc;
                if (selReady) begin
                    memory_ready = 1'b1;
                    memory_rdata = selRdata;
                    sel_d        = SEL_NONE;
                    state_d      = IDLE;
                end else if (timeoutHit) begin
                    memory_ready = 1'b1;
                    memory_error = 1'b1;
                    sel_d        = SEL_NONE;
                    state_d      = IDLE;
                end
            end
            ERR: begin
                memory_ready = 1'b1;
                memory_error = 1'b1;
                sel_d        = SEL_NONE;
                state_d      = IDLE;
            end
            default: begin
                sel_d   = SEL_NONE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= SEL_NONE;
            cnt_q   <= '0;
            instr_q <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

endmodule

// File: tb/tb_mem_router.sv
// Randomized and directed bench for mem_router, checked against an address-range
// model of the memory map and a per-transaction completion-cycle prediction.
module tb_mem_router;

    localparam int TIMEOUT = 8;

    logic        clk, rst;
    logic        memory_valid, memory_instr;
    logic [31:0] memory_addr, memory_wdata, memory_rdata;
    logic [3:0]  memory_wstrb;
    logic        memory_ready, memory_error;
    logic        slv_instr;
    logic [31:0] slv_addr, slv_wdata;
    logic [3:0]  slv_wstrb;
    logic        ram_valid, uart_valid, timer_valid;
    logic        ram_ready, uart_ready, timer_ready;
    logic [31:0] ram_rdata, uart_rdata, timer_rdata;

    int compared   = 0;
    int mismatched = 0;

    mem_router #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .memory_valid(memory_valid), .memory_instr(memory_instr),
        .memory_addr(memory_addr), .memory_wdata(memory_wdata),
        .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
        .memory_ready(memory_ready), .memory_error(memory_error),
        .slv_instr(slv_instr), .slv_addr(slv_addr),
        .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
        .ram_valid(ram_valid), .uart_valid(uart_valid), .timer_valid(timer_valid),
        .ram_ready(ram_ready), .uart_ready(uart_ready), .timer_ready(timer_ready),
        .ram_rdata(ram_rdata), .uart_rdata(uart_rdata), .timer_rdata(timer_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory map as plain address ranges: 0 none, 1 RAM, 2 UART, 3 timer.
    function automatic int expRegion(input logic [31:0] a);
        if (a < 32'h0010_0000) return 1;
        if (a >= 32'h1000_0000 && a < 32'h1000_1000) return 2;
        if (a >= 32'h2000_0000 && a < 32'h2001_0000) return 3;
        return 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " ready"}, memory_ready, 0);
        checkOutput({tag, " error"}, memory_error, 0);
        checkOutput({tag, " rdata"}, memory_rdata, 0);
        checkOutput({tag, " valids"}, {ram_valid, uart_valid, timer_valid}, 0);
    endtask

    // One transaction: delay is the slave's ready offset from its valid pulse, -1 = never.
    task automatic applyStimulus(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input int delay, input logic [31:0] respData,
                                 input logic junkValid);
        int region, doneK;
        logic expErr, slaveHit, readyNow;
        logic [31:0] expRdata;
        region = expRegion(addr);
        expErr = (region == 0) || (instr && region != 1);
        if (expErr) doneK = 0;
        else if (delay >= 0 && delay < TIMEOUT) doneK = delay;
        else doneK = TIMEOUT;

        memory_valid = 1'b1; memory_instr = instr; memory_addr = addr;
        memory_wdata = wdata; memory_wstrb = wstrb;
        @(posedge clk); @(negedge clk);
        memory_valid = 1'b0; memory_instr = ~instr; memory_addr = $urandom;
        memory_wdata = $urandom; memory_wstrb = 4'($urandom);

        for (int k = 0; k <= doneK; k++) begin
            slaveHit = !expErr && (delay >= 0) && (k == delay);
            ram_ready = 1'($urandom); uart_ready = 1'($urandom); timer_ready = 1'($urandom);
            ram_rdata = $urandom; uart_rdata = $urandom; timer_rdata = $urandom;
            if (!expErr) begin
                case (region)
                    1: begin ram_ready = slaveHit;   if (slaveHit) ram_rdata = respData;   end
                    2: begin uart_ready = slaveHit;  if (slaveHit) uart_rdata = respData;  end
                    default: begin timer_ready = slaveHit; if (slaveHit) timer_rdata = respData; end
                endcase
            end
            if (junkValid && k >= 1) begin
                memory_valid = 1'b1;
                memory_addr  = $urandom;
            end else begin
                memory_valid = 1'b0;
            end
            #1;
            readyNow = (k == doneK);
            expRdata = (readyNow && slaveHit) ? respData : 32'h0;
            checkOutput("memory_ready", memory_ready, readyNow);
            checkOutput("memory_error", memory_error, readyNow && !slaveHit);
            checkOutput("memory_rdata", memory_rdata, expRdata);
            checkOutput("ram_valid", ram_valid, k == 0 && !expErr && region == 1);
            checkOutput("uart_valid", uart_valid, k == 0 && !expErr && region == 2);
            checkOutput("timer_valid", timer_valid, k == 0 && !expErr && region == 3);
            checkOutput("slv_addr", slv_addr, addr);
            if (k == 0) begin
                checkOutput("slv_instr", slv_instr, instr);
                checkOutput("slv_wdata", slv_wdata, wdata);
                checkOutput("slv_wstrb", slv_wstrb, wstrb);
            end
            if (k < doneK) begin
                @(posedge clk); @(negedge clk);
            end
        end

        @(posedge clk); @(negedge clk);
        memory_valid = 1'b0;
        ram_ready = 1'b0; uart_ready = 1'b0; timer_ready = 1'b0;
        #1;
        checkIdleOutputs("post-txn");
    endtask

    initial begin
        logic [31:0] a;
        int d;
        rst = 1'b0;
        memory_valid = 1'b0; memory_instr = 1'b0; memory_addr = 32'h0;
        memory_wdata = 32'h0; memory_wstrb = 4'h0;
        ram_ready = 1'b0; uart_ready = 1'b0; timer_ready = 1'b0;
        ram_rdata = 32'h0; uart_rdata = 32'h0; timer_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checkIdleOutputs("reset");
        checkOutput("reset slv", {31'h0, slv_instr} | slv_addr | slv_wdata | {28'h0, slv_wstrb}, 0);
        rst = 1'b1;

        // Directed cases from the block's intended usage.
        applyStimulus(1'b0, 32'h0000_0100, 32'h0, 4'h0, 2, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(1'b0, 32'h1000_0004, 32'h41, 4'b0001, 0, $urandom, 1'b0);
        applyStimulus(1'b1, 32'h1000_0000, 32'h0, 4'h0, 0, $urandom, 1'b0);
        applyStimulus(1'b0, 32'h3000_0000, 32'h0, 4'h0, 0, $urandom, 1'b0);
        applyStimulus(1'b1, 32'h0000_0040, 32'h0, 4'h0, 1, 32'h1234_5678, 1'b0);

        // Timeout followed by a late ready that must be dropped.
        applyStimulus(1'b0, 32'h2000_0010, 32'h0, 4'h0, -1, 32'h0, 1'b0);
        @(posedge clk); @(negedge clk);
        timer_ready = 1'b1; timer_rdata = 32'hCAFE_F00D;
        #1;
        checkOutput("late ready", memory_ready, 0);
        checkOutput("late rdata", memory_rdata, 0);
        @(posedge clk); @(negedge clk);
        timer_ready = 1'b0;

        // Stray memory_valid during WAIT, then back-to-back zero-wait RAM reads.
        applyStimulus(1'b0, 32'h0000_0200, 32'h0, 4'h0, 4, 32'h0BAD_F00D, 1'b1);
        applyStimulus(1'b0, 32'h0000_0300, 32'h0, 4'h0, 0, 32'h1111_1111, 1'b0);
        applyStimulus(1'b0, 32'h0000_0304, 32'h0, 4'h0, 0, 32'h2222_2222, 1'b0);

        // Reset while waiting on a RAM slave that never answers.
        memory_valid = 1'b1; memory_instr = 1'b0; memory_addr = 32'h0000_0400;
        memory_wdata = 32'h55; memory_wstrb = 4'hF;
        @(posedge clk); @(negedge clk);
        memory_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        checkIdleOutputs("mid reset");
        checkOutput("mid reset slv_addr", slv_addr, 0);
        checkOutput("mid reset slv_wdata", slv_wdata, 0);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1, 32'hA5A5_5A5A, 1'b0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: a = $urandom & 32'h000F_FFFF;
                1: a = 32'h1000_0000 | ($urandom & 32'h0000_0FFF);
                2: a = 32'h2000_0000 | ($urandom & 32'h0000_FFFF);
                3: a = $urandom;
                default: a = 32'h1000_1000 | ($urandom & 32'h0000_0FFF);
            endcase
            d = $urandom_range(0, 9);
            if (d > 6) d = -1;
            applyStimulus(($urandom_range(0, 3) == 0), a, $urandom, 4'($urandom), d, $urandom,
                          1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
